riscv_hazard_unit: RTL and testbench

Parametrised hazard-detection and forwarding controller for the pipelined RISC-V core. Tracks every in-flight register-writing instruction past decode in a shift-register scoreboard. Drives operand-forwarding selects, load-use stalls and branch-redirect flushes for a configurable number of post-decode stages, so the core can grow from the current 3-stage arrangement to deeper pipelines without redesign. Sits beside the main decoder and feeds the pipeline registers and the operand muxes.

---
 rtl/riscv_hazard_unit.sv | 103 ++++++++++
 tb/tb_riscv_hazard_unit.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/riscv_hazard_unit.sv
// Hazard detection and operand forwarding built on a shift-register scoreboard of in-flight writers.
// Optional HAZARD_PERF_EN adds free-running stall/flush event counters.
module riscv_hazard_unit #(
  parameter int unsigned REGW       = 5,
  parameter int unsigned NUM_STAGES = 2,
  parameter int unsigned LOAD_STAGE = 2,
  parameter int unsigned SELW       = $clog2(NUM_STAGES + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            dec_valid_i,
  input  logic [REGW-1:0] dec_rs1_i,
  input  logic [REGW-1:0] dec_rs2_i,
  input  logic            dec_rs1_used_i,
  input  logic            dec_rs2_used_i,
  input  logic [REGW-1:0] dec_rd_i,
  input  logic            dec_reg_write_i,
  input  logic            dec_is_load_i,
  input  logic            redirect_i,
  output logic            stall_f_o,
  output logic            stall_d_o,
  output logic            flush_d_o,
  output logic [SELW-1:0] fwd_a_o,
  output logic [SELW-1:0] fwd_b_o
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]     stall_cnt_o,
  output logic [31:0]     flush_cnt_o
`endif
);

  logic            sb_valid [1:NUM_STAGES];
  logic [REGW-1:0] sb_rd    [1:NUM_STAGES];
  logic            sb_we    [1:NUM_STAGES];
  logic            sb_load  [1:NUM_STAGES];

  logic            not_ready_a;
  logic            not_ready_b;
  logic            push;

  // Scan oldest to youngest so the youngest matching producer overrides.
  always_comb begin
    fwd_a_o     = '0;
    fwd_b_o     = '0;
    not_ready_a = 1'b0;
    not_ready_b = 1'b0;
    for (int k = int'(NUM_STAGES); k >= 1; k--) begin
      if (sb_valid[k] && sb_we[k] && (sb_rd[k] == dec_rs1_i) && (dec_rs1_i != '0) &&
          dec_rs1_used_i && dec_valid_i) begin
        fwd_a_o     = SELW'(k);
        not_ready_a = sb_load[k] && (k < int'(LOAD_STAGE));
      end
      if (sb_valid[k] && sb_we[k] && (sb_rd[k] == dec_rs2_i) && (dec_rs2_i != '0) &&
          dec_rs2_used_i && dec_valid_i) begin
        fwd_b_o     = SELW'(k);
        not_ready_b = sb_load[k] && (k < int'(LOAD_STAGE));
      end
    end
  end

  // A redirect squashes decode, so it overrides any load-use stall.
  always_comb begin
    flush_d_o = redirect_i;
    stall_d_o = (not_ready_a || not_ready_b) && !redirect_i;
    stall_f_o = stall_d_o;
    push      = dec_valid_i && !stall_d_o && !flush_d_o;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 1; k <= int'(NUM_STAGES); k++) begin
        sb_valid[k] <= 1'b0;
        sb_rd[k]    <= '0;
        sb_we[k]    <= 1'b0;
        sb_load[k]  <= 1'b0;
      end
    end else begin
      sb_valid[1] <= push;
      sb_rd[1]    <= dec_rd_i;
      sb_we[1]    <= dec_reg_write_i;
      sb_load[1]  <= dec_is_load_i;
      for (int k = 2; k <= int'(NUM_STAGES); k++) begin
        sb_valid[k] <= sb_valid[k-1];
        sb_rd[k]    <= sb_rd[k-1];
        sb_we[k]    <= sb_we[k-1];
        sb_load[k]  <= sb_load[k-1];
      end
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (stall_d_o) stall_cnt_o <= stall_cnt_o + 32'd1;
      if (flush_d_o) flush_cnt_o <= flush_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_riscv_hazard_unit.sv
// Directed-vector bench: default-geometry instance plus a NUM_STAGES=4 / LOAD_STAGE=3 instance on shared inputs.
module tb_riscv_hazard_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       dec_valid;
  logic [4:0] dec_rs1, dec_rs2, dec_rd;
  logic       dec_rs1_used, dec_rs2_used, dec_reg_write, dec_is_load;
  logic       redirect;

  logic       a_stall_f, a_stall_d, a_flush_d;
  logic [1:0] a_fwd_a, a_fwd_b;
  logic       b_stall_f, b_stall_d, b_flush_d;
  logic [2:0] b_fwd_a, b_fwd_b;
`ifdef HAZARD_PERF_EN
  logic [31:0] a_stall_cnt, a_flush_cnt, b_stall_cnt, b_flush_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  riscv_hazard_unit dut (
    .clk_i(clk), .rst_i(rst), .dec_valid_i(dec_valid),
    .dec_rs1_i(dec_rs1), .dec_rs2_i(dec_rs2),
    .dec_rs1_used_i(dec_rs1_used), .dec_rs2_used_i(dec_rs2_used),
    .dec_rd_i(dec_rd), .dec_reg_write_i(dec_reg_write), .dec_is_load_i(dec_is_load),
    .redirect_i(redirect), .stall_f_o(a_stall_f), .stall_d_o(a_stall_d),
    .flush_d_o(a_flush_d), .fwd_a_o(a_fwd_a), .fwd_b_o(a_fwd_b)
`ifdef HAZARD_PERF_EN
    , .stall_cnt_o(a_stall_cnt), .flush_cnt_o(a_flush_cnt)
`endif
  );

  riscv_hazard_unit #(.NUM_STAGES(4), .LOAD_STAGE(3)) dut4 (
    .clk_i(clk), .rst_i(rst), .dec_valid_i(dec_valid),
    .dec_rs1_i(dec_rs1), .dec_rs2_i(dec_rs2),
    .dec_rs1_used_i(dec_rs1_used), .dec_rs2_used_i(dec_rs2_used),
    .dec_rd_i(dec_rd), .dec_reg_write_i(dec_reg_write), .dec_is_load_i(dec_is_load),
    .redirect_i(redirect), .stall_f_o(b_stall_f), .stall_d_o(b_stall_d),
    .flush_d_o(b_flush_d), .fwd_a_o(b_fwd_a), .fwd_b_o(b_fwd_b)
`ifdef HAZARD_PERF_EN
    , .stall_cnt_o(b_stall_cnt), .flush_cnt_o(b_flush_cnt)
`endif
  );

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present one decode-stage instruction; outputs settle 1ns later.
  task automatic set_dec(input logic v, input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                         input logic we, input logic ld, input logic redir);
    dec_valid = v; dec_rs1 = rs1; dec_rs1_used = u1; dec_rs2 = rs2; dec_rs2_used = u2;
    dec_rd = rd; dec_reg_write = we; dec_is_load = ld; redirect = redir;
    #1;
  endtask

  task automatic nop();
    set_dec(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_a(input string tag, input int unsigned st, input int unsigned fl,
                         input int unsigned fa, input int unsigned fb);
    check({tag, ".stall_d"}, a_stall_d, st);
    check({tag, ".stall_f"}, a_stall_f, st);
    check({tag, ".flush_d"}, a_flush_d, fl);
    check({tag, ".fwd_a"}, a_fwd_a, fa);
    check({tag, ".fwd_b"}, a_fwd_b, fb);
  endtask

  initial begin
    rst = 1'b1;
    nop();
    step(); step();

    // flush follows redirect even in reset
    set_dec(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    check("rst_flush", a_flush_d, 1);
    step();
    rst = 1'b0;
    // empty scoreboard: reader of x5 sees nothing
    set_dec(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    check_a("empty", 0, 0, 0, 0);
    nop(); step();

    // addi x5 ; add x6,x5,x5
    set_dec(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0); step();
    set_dec(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
    check_a("alu_d1", 0, 0, 1, 1);
    step();
    // addi x5 ; add x10,x1,x2 ; add x11,x5,x5
    set_dec(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0); step();
    set_dec(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0);
    check_a("unrel", 0, 0, 0, 0);
    step();
    set_dec(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd11, 1'b1, 1'b0, 1'b0);
    check_a("alu_d2", 0, 0, 2, 2);
    step();

    // lw x7 ; add x8,x7,x1 -> one stall cycle then fwd 2
    set_dec(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0); step();
    set_dec(1'b1, 5'd7, 1'b1, 5'd1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
    check_a("lu_stall", 1, 0, 1, 0);
    step();
    check_a("lu_issue", 0, 0, 2, 0);
    step();

    // x0 never a hazard
    set_dec(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0); step();
    set_dec(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
    check_a("x0", 0, 0, 0, 0);
    step();
    // two writers of x9: youngest wins
    set_dec(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0); step();
    set_dec(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0); step();
    set_dec(1'b1, 5'd9, 1'b1, 5'd9, 1'b1, 5'd12, 1'b1, 1'b0, 1'b0);
    check_a("youngest", 0, 0, 1, 1);
    step();

    // load-use coinciding with redirect: flush only, bubble pushed
    set_dec(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0); step();
    set_dec(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd13, 1'b1, 1'b0, 1'b1);
    check_a("redir", 0, 1, 1, 0);
    step();
    set_dec(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd13, 1'b1, 1'b0, 1'b0);
    check_a("post_redir", 0, 0, 2, 0);
    step();

`ifdef HAZARD_PERF_EN
    nop(); rst = 1'b1; step(); rst = 1'b0;
    check("cnt_rst_stall", a_stall_cnt, 0);
    check("cnt_rst_flush", a_flush_cnt, 0);
    for (int i = 0; i < 3; i++) begin
      set_dec(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0); step();
      set_dec(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0); step(); step();
    end
    for (int i = 0; i < 2; i++) begin
      set_dec(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1); step();
    end
    nop();
    check("cnt_stall", a_stall_cnt, 3);
    check("cnt_flush", a_flush_cnt, 2);
    rst = 1'b1; step(); rst = 1'b0;
    check("cnt_stall_clr", a_stall_cnt, 0);
    check("cnt_flush_clr", a_flush_cnt, 0);
`endif

    // deeper pipeline: two stall cycles, then fwd 3
    nop(); rst = 1'b1; step(); rst = 1'b0;
    set_dec(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0); step();
    set_dec(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0);
    check("d4_stall1", b_stall_d, 1);
    check("d4_stall1_f", b_stall_f, 1);
    check("d4_fwd1", b_fwd_a, 1);
    step();
    check("d4_stall2", b_stall_d, 1);
    check("d4_fwd2", b_fwd_a, 2);
    step();
    check("d4_issue", b_stall_d, 0);
    check("d4_fwd3", b_fwd_a, 3);
    step();

    // reset during the first stall cycle empties the scoreboard
    set_dec(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0); step();
    set_dec(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0);
    check("d4_pre_rst", b_stall_d, 1);
    rst = 1'b1; step(); rst = 1'b0;
    #1;
    check("d4_rst_stall", b_stall_d, 0);
    check("d4_rst_fwd", b_fwd_a, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
